// File: rtl/serial_sub4.sv
// Bit-serial subtractor D = A - B - Bin built from one full-adder cell, one bit per clock.
// Optional macro SERIAL_SUB4_ADDMODE_EN adds a Mode input (1 = add, 0 = subtract).
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
`ifdef SERIAL_SUB4_ADDMODE_EN
  input  logic             Mode,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LASTBIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSBIN   = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] resReg;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cmsb;
  logic             bBit;
  logic             sum;
  logic             carryNext;
  logic             borrowOut;
`ifdef SERIAL_SUB4_ADDMODE_EN
  logic             modeReg;
`endif

  // Single full-adder cell; subtraction feeds the inverted B bit and reports the inverted carry.
  always_comb begin
`ifdef SERIAL_SUB4_ADDMODE_EN
    bBit      = modeReg ? bReg[0] : ~bReg[0];
`else
    bBit      = ~bReg[0];
`endif
    sum       = aReg[0] ^ bBit ^ carry;
    carryNext = (aReg[0] & bBit) | (aReg[0] & carry) | (bBit & carry);
`ifdef SERIAL_SUB4_ADDMODE_EN
    borrowOut = modeReg ? carryNext : ~carryNext;
`else
    borrowOut = ~carryNext;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
      V      <= 1'b0;
      aReg   <= '0;
      bReg   <= '0;
      resReg <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cmsb   <= 1'b0;
`ifdef SERIAL_SUB4_ADDMODE_EN
      modeReg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            aReg  <= A;
            bReg  <= B;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= SHIFT;
`ifdef SERIAL_SUB4_ADDMODE_EN
            modeReg <= Mode;
            carry   <= Mode ? Bin : ~Bin;
`else
            carry   <= ~Bin;
`endif
          end
        end
        SHIFT: begin
          aReg   <= aReg >> 1;
          bReg   <= bReg >> 1;
          resReg <= {sum, resReg[WIDTH-1:1]};
          carry  <= carryNext;
          cnt    <= cnt + 1'b1;
          if (cnt == MSBIN)
            cmsb <= carryNext;
          // Final bit: results are registered here so they are valid throughout FIN.
          if (cnt == LASTBIT) begin
            D     <= {sum, resReg[WIDTH-1:1]};
            Bout  <= borrowOut;
            V     <= cmsb ^ carryNext;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4: directed vector table plus held-Start and mid-operation reset sequences.
module tb_serial_sub4;

  localparam int WIDTH = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             V;
`ifdef SERIAL_SUB4_ADDMODE_EN
  logic             Mode;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             v;
  } vec_t;

  vec_t vecs[10];

  serial_sub4 #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
`ifdef SERIAL_SUB4_ADDMODE_EN
    .Mode  (Mode),
`endif
    .Busy  (Busy),
    .Done  (Done),
    .D     (D),
    .Bout  (Bout),
    .V     (V)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Present operands for one cycle of Start, then scramble them so only the latched copy matters.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    @(negedge CLK);
    A = a; B = b; Bin = bin; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    A = ~a; B = ~b; Bin = ~bin;
  endtask

  // Called in the first cycle after acceptance; walks the Busy window and checks the Done cycle.
  task automatic checkOutput(input vec_t v);
    int k;
    logic seen;
    k = 1;
    seen = 1'b0;
    while (k <= 12 && !seen) begin
      if (Done) begin
        seen = 1'b1;
      end else begin
        check("busy_window", Busy, k <= WIDTH);
        @(negedge CLK);
        A = WIDTH'($urandom);
        B = WIDTH'($urandom);
        k++;
      end
    end
    check("done_seen", seen, 1'b1);
    check("latency", k, WIDTH + 1);
    check("busy_in_fin", Busy, 1'b0);
    check("d", D, v.d);
    check("bout", Bout, v.bout);
    check("v", V, v.v);
    @(negedge CLK);
    check("done_single_pulse", Done, 1'b0);
    check("d_held", D, v.d);
  endtask

  initial begin
    logic doneSeen;
    RST = 1'b1; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
`ifdef SERIAL_SUB4_ADDMODE_EN
    Mode = 1'b0;
`endif

    vecs[0] = '{4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0};
    vecs[1] = '{4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0};
    vecs[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[3] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[4] = '{4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1};
    vecs[5] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};
    vecs[6] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[7] = '{4'b1000, 4'b0111, 1'b1, 4'b0000, 1'b0, 1'b1};
    vecs[8] = '{4'b1010, 4'b0011, 1'b1, 4'b0110, 1'b0, 1'b1};
    vecs[9] = '{4'b0110, 4'b1101, 1'b0, 4'b1001, 1'b1, 1'b1};

    repeat (2) @(negedge CLK);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_d", D, 4'b0000);
    check("rst_bout", Bout, 1'b0);
    check("rst_v", V, 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_busy", Busy, 1'b0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin);
      checkOutput(vecs[i]);
    end

    // Start held high: second operation is latched on the IDLE cycle after Done.
    @(negedge CLK);
    A = 4'b0101; B = 4'b0011; Bin = 1'b0; Start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge CLK);
      if (k == 5) begin
        check("held_done1", Done, 1'b1);
        check("held_d1", D, 4'b0010);
      end
      if (k == 6) begin
        check("held_idle_busy", Busy, 1'b0);
        check("held_idle_done", Done, 1'b0);
      end
      if (k == 7)
        check("held_accept2", Busy, 1'b1);
      if (k == 11) begin
        check("held_done2", Done, 1'b1);
        check("held_d2", D, 4'b1110);
        check("held_bout2", Bout, 1'b1);
        check("held_v2", V, 1'b0);
        Start = 1'b0;
      end
      if (k == 6) begin
        A = 4'b0011; B = 4'b0101; Bin = 1'b0;
      end else begin
        A = WIDTH'($urandom); B = WIDTH'($urandom); Bin = 1'($urandom);
      end
    end

    // Asynchronous reset during the second SHIFT cycle.
    @(negedge CLK);
    A = 4'b1001; B = 4'b0010; Bin = 1'b0; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    check("abort_busy_before", Busy, 1'b1);
    @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    check("abort_busy", Busy, 1'b0);
    check("abort_d", D, 4'b0000);
    check("abort_bout", Bout, 1'b0);
    check("abort_v", V, 1'b0);
    check("abort_done", Done, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    doneSeen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      doneSeen = doneSeen | Done;
    end
    check("abort_no_done", doneSeen, 1'b0);
    applyStimulus(vecs[0].a, vecs[0].b, vecs[0].bin);
    checkOutput(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
